// File: rtl/reg_scoreboard_if.sv
// Decode/Writeback <-> scoreboard signal bundle. Decode and Writeback drive the
// master side; the scoreboard sits on the slave side.
interface reg_scoreboard_if #(
  parameter int NUM_RF = 16,
  parameter int IDX_W  = $clog2(NUM_RF)
);
  logic              I_IssueValid;
  logic              I_DestValid;
  logic [IDX_W-1:0]  I_DestIdx;
  logic              I_SetsCC;
  logic              I_Src1Valid;
  logic              I_Src2Valid;
  logic              I_Src3Valid;
  logic [IDX_W-1:0]  I_Src1Idx;
  logic [IDX_W-1:0]  I_Src2Idx;
  logic [IDX_W-1:0]  I_Src3Idx;
  logic              I_NeedCC;
  logic              I_WBValid;
  logic [IDX_W-1:0]  I_WBIdx;
  logic              I_WBSetsCC;
  logic              I_Flush;
  logic              O_DepStall;
  logic              O_IssueAccept;
  logic [NUM_RF-1:0] O_Busy;
  logic              O_CCPending;
  logic              O_Error;

  modport master (
    output I_IssueValid, I_DestValid, I_DestIdx, I_SetsCC,
           I_Src1Valid, I_Src2Valid, I_Src3Valid,
           I_Src1Idx, I_Src2Idx, I_Src3Idx, I_NeedCC,
           I_WBValid, I_WBIdx, I_WBSetsCC, I_Flush,
    input  O_DepStall, O_IssueAccept, O_Busy, O_CCPending, O_Error
  );

  modport slave (
    input  I_IssueValid, I_DestValid, I_DestIdx, I_SetsCC,
           I_Src1Valid, I_Src2Valid, I_Src3Valid,
           I_Src1Idx, I_Src2Idx, I_Src3Idx, I_NeedCC,
           I_WBValid, I_WBIdx, I_WBSetsCC, I_Flush,
    output O_DepStall, O_IssueAccept, O_Busy, O_CCPending, O_Error
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Pipeline dependency scoreboard: per-register pending-write counters plus an
// outstanding condition-code producer counter, with same-cycle WB bypass.
module reg_scoreboard #(
  parameter int NUM_RF       = 16,
  parameter int CNT_WIDTH    = 2,
  parameter int CC_CNT_WIDTH = 3
) (
  input logic              I_CLOCK,
  input logic              I_RESET,
  reg_scoreboard_if.slave  sb
);
  localparam int IDX_W = $clog2(NUM_RF);

  typedef logic [CNT_WIDTH-1:0]    cnt_t;
  typedef logic [CC_CNT_WIDTH-1:0] cc_cnt_t;

  cnt_t              cnt_q [NUM_RF];
  cnt_t              cnt_d [NUM_RF];
  cc_cnt_t           cc_q, cc_d;
  logic [NUM_RF-1:0] busy_q, busy_d;
  logic              cc_pend_q, cc_pend_d;
  logic              err_q, err_d;

  logic [NUM_RF-1:0] wb_hit, reg_haz, reg_sat, reg_inc;
  logic              src_haz, cc_haz, struct_haz;
  logic              dep_stall, issue_accept;
  logic              cc_inc, cc_dec;

  // A register is a RAW hazard unless its only pending writer retires this
  // cycle; Decode sees that value through the first-half-cycle RF write.
  always_comb begin
    for (int i = 0; i < NUM_RF; i++) begin
      wb_hit[i]  = sb.I_WBValid && (sb.I_WBIdx == IDX_W'(i));
      reg_haz[i] = (cnt_q[i] != '0) && !(wb_hit[i] && (cnt_q[i] == cnt_t'(1)));
      reg_sat[i] = &cnt_q[i];
    end
  end

  always_comb begin
    src_haz      = (sb.I_Src1Valid && reg_haz[sb.I_Src1Idx]) ||
                   (sb.I_Src2Valid && reg_haz[sb.I_Src2Idx]) ||
                   (sb.I_Src3Valid && reg_haz[sb.I_Src3Idx]);
    cc_haz       = sb.I_NeedCC && (cc_q != '0) &&
                   !((cc_q == cc_cnt_t'(1)) && sb.I_WBValid && sb.I_WBSetsCC);
    struct_haz   = sb.I_DestValid && reg_sat[sb.I_DestIdx] && !wb_hit[sb.I_DestIdx];
    dep_stall    = sb.I_IssueValid && (src_haz || cc_haz || struct_haz);
    issue_accept = sb.I_IssueValid && !dep_stall && !sb.I_Flush;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    err_d  = err_q;
    cc_d   = cc_q;
    cc_inc = issue_accept && sb.I_DestValid && sb.I_SetsCC;
    cc_dec = sb.I_WBValid && sb.I_WBSetsCC;
    for (int i = 0; i < NUM_RF; i++) begin
      cnt_d[i]   = cnt_q[i];
      reg_inc[i] = issue_accept && sb.I_DestValid && (sb.I_DestIdx == IDX_W'(i));
    end

    if (sb.I_Flush) begin
      for (int i = 0; i < NUM_RF; i++) cnt_d[i] = '0;
      cc_d = '0;
    end else begin
      for (int i = 0; i < NUM_RF; i++) begin
        if (reg_inc[i] && !wb_hit[i]) begin
          if (reg_sat[i]) err_d = 1'b1;
          else            cnt_d[i] = cnt_q[i] + 1'b1;
        end else if (wb_hit[i] && !reg_inc[i]) begin
          if (cnt_q[i] == '0) err_d = 1'b1;
          else                cnt_d[i] = cnt_q[i] - 1'b1;
        end
      end
      if (cc_inc && !cc_dec) begin
        if (&cc_q) err_d = 1'b1;
        else       cc_d  = cc_q + 1'b1;
      end else if (cc_dec && !cc_inc) begin
        if (cc_q == '0) err_d = 1'b1;
        else            cc_d  = cc_q - 1'b1;
      end
    end

    for (int i = 0; i < NUM_RF; i++) busy_d[i] = (cnt_d[i] != '0);
    cc_pend_d = (cc_d != '0);
  end

  // NOTE: the counter array is architectural state, not RAM, so it is reset.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      for (int i = 0; i < NUM_RF; i++) cnt_q[i] <= '0;
      cc_q      <= '0;
      busy_q    <= '0;
      cc_pend_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_RF; i++) cnt_q[i] <= cnt_d[i];
      cc_q      <= cc_d;
      busy_q    <= busy_d;
      cc_pend_q <= cc_pend_d;
      err_q     <= err_d;
    end
  end

  assign sb.O_DepStall    = dep_stall;
  assign sb.O_IssueAccept = issue_accept;
  assign sb.O_Busy        = busy_q;
  assign sb.O_CCPending   = cc_pend_q;
  assign sb.O_Error       = err_q;
endmodule
